multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the MIPS-subset CPU. It replaces the single-cycle opcode decoder. It sequences one shared memory, one ALU and the PC/IR/register-file write enables over 3-5 cycles per instruction. It stalls on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
ILL_TRAP, 0, 1 = stay in ILLEGAL state until reset; 0 = skip the instruction and continue

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous active-high reset
instr_op_i  input  6  opcode from IR[31:26], valid from DECODE onward
mem_ready_i  input  1  shared memory completes access this cycle
PCWrite_o  output  1  unconditional PC load
PCWriteCond_o  output  1  PC load if ALU zero (beq)
IorD_o  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead_o  output  1  memory read request
MemWrite_o  output  1  memory write request
IRWrite_o  output  1  instruction register load
MemtoReg_o  output  1  RF write data: 0 = ALUOut, 1 = MDR
RegDst_o  output  1  RF write address: 0 = rt, 1 = rd
RegWrite_o  output  1  RF write enable
ALUSrcA_o  output  1  0 = PC, 1 = rs data
ALUSrcB_o  output  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALU_op_o  output  3  000 add, 001 sub, 010 use funct, 011 slt
PCSource_o  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state_o  output  4  current state encoding, for debug
illegal_o  output  1  one-cycle pulse on unsupported opcode
retired_o  output  CNT_W  completed-instruction count

Behaviour:
- Reset: asynchronous. State is forced to FETCH, retired_o = 0, illegal_o = 0. While rst_i is high, every control output is 0, even though the state is FETCH. Reset asserted mid-instruction aborts it with no further writes.
- Encodings: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11, ILLEGAL = 12. Codes 13-15 are unreachable; if entered, go to FETCH next cycle.
- Control outputs are Moore decodes of the state. The exception is any enable gated by mem_ready_i, as noted below. Every signal not listed for a state is 0.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALU_op = 000, PCSource = 00.
  - IRWrite and PCWrite = mem_ready_i.
  - Stay in FETCH while mem_ready_i = 0; go to DECODE when it is 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALU_op = 000 (branch-target precompute). Next state by opcode:
  - 0x00 -> R_EXEC
  - 0x23 lw or 0x2B sw -> MEM_ADDR
  - 0x04 beq -> BRANCH
  - 0x02 j -> JUMP
  - 0x08 addi or 0x0A slti -> I_EXEC
  - any other opcode -> ILLEGAL
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALU_op = 000. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead = 1, IorD = 1. Wait for mem_ready_i, then go to MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Retire, then go to FETCH.
- MEM_WR: MemWrite = 1, IorD = 1. Wait for mem_ready_i, then retire and go to FETCH. MemWrite stays high throughout the stall.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALU_op = 010. Go to R_WB.
- R_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Retire, then go to FETCH.
- I_EXEC: ALUSrcA = 1, ALUSrcB = 10. ALU_op = 000 for addi, 011 for slti. Go to I_WB.
- I_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0. ALU_op is held from I_EXEC. Retire, then go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALU_op = 001, PCWriteCond = 1, PCSource = 01. Retire, then go to FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Retire, then go to FETCH.
- ILLEGAL: illegal_o = 1 for exactly the cycle after DECODE. Then:
  - ILL_TRAP = 0: go to FETCH with no retire.
  - ILL_TRAP = 1: hold in ILLEGAL with illegal_o low after the first cycle.
- Opcode capture: the opcode is registered in DECODE. Later states use the registered copy, so IR changes after DECODE have no effect.
- Retire: retired_o increments by 1 on the clock edge leaving a final state. It wraps from 2^CNT_W - 1 to 0. A final state that is held by a stall does not count until it exits.
- Latency, cycles FETCH to FETCH with mem_ready_i always 1: R-type 4, addi/slti 4, lw 5, sw 4, beq 3, j 3.

Test Plan:
- Reset: assert rst_i mid-MEM_RD -> outputs 0 immediately (async); state_o = 0 and retired_o = 0 after release; first cycle after release shows MemRead = 1, IRWrite = 1.
- R-type, ready tied 1: op 0x00 -> states 0,1,6,7,0; RegWrite = 1 with RegDst = 1 only in state 7; retired_o 0 -> 1.
- lw with 3-cycle stall in MEM_RD (ready = 0,0,0,1) -> MemRead and IorD = 1 held 4 cycles; MEM_WB follows; total 8 cycles; RegWrite pulses exactly once.
- beq then j: op 0x04 -> PCWriteCond = 1, ALU_op = 001 in state 8; op 0x02 -> PCWrite = 1, PCSource = 10 in state 9; retired_o = 2.
- Illegal op 0x3F, ILL_TRAP = 0 -> illegal_o high 1 cycle, back to FETCH, retired_o unchanged; repeat with ILL_TRAP = 1 -> state_o stays 12 until rst_i.
- Counter wrap with CNT_W = 4: 17 back-to-back j instructions -> retired_o reads 15 after the 15th and 1 after the 17th.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset main control FSM.
// Sequences shared memory, ALU and write enables; counts retired instructions.
module multi_cycle_ctrl #(
  parameter int CNT_W    = 16,
  parameter bit ILL_TRAP = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemtoReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALU_op_o,
  output logic [1:0]       PCSource_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [5:0]       op_q;
  logic             ill_first;
  logic             retire;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       i_alu_op;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_FETCH;
      op_q      <= 6'h00;
      ill_first <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= nxt;
      if (state == S_DECODE)
        op_q <= instr_op_i;
      ill_first <= (state == S_DECODE) && (nxt == S_ILLEGAL);
      if (retire)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt    = state;
    retire = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready_i)
          nxt = S_DECODE;
      end
      S_DECODE: begin
        case (instr_op_i)
          OP_R:           nxt = S_R_EXEC;
          OP_LW, OP_SW:   nxt = S_MEM_ADDR;
          OP_BEQ:         nxt = S_BRANCH;
          OP_J:           nxt = S_JUMP;
          OP_ADDI,
          OP_SLTI:        nxt = S_I_EXEC;
          default:        nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready_i)
          nxt = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (mem_ready_i) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end
      end
      S_R_EXEC: nxt = S_R_WB;
      S_I_EXEC: nxt = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_ILLEGAL: begin
        nxt = ILL_TRAP ? S_ILLEGAL : S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // slti selects set-less-than; held into write-back
  assign i_alu_op = (op_q == OP_SLTI) ? 3'b011 : 3'b000;

  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALU_op_o      = 3'b000;
    PCSource_o    = 2'b00;
    illegal_o     = 1'b0;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = 2'b01;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        S_DECODE: begin
          ALUSrcB_o = 2'b11;
        end
        S_MEM_ADDR: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
        end
        S_MEM_RD: begin
          MemRead_o = 1'b1;
          IorD_o    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite_o = 1'b1;
          MemtoReg_o = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite_o = 1'b1;
          IorD_o     = 1'b1;
        end
        S_R_EXEC: begin
          ALUSrcA_o = 1'b1;
          ALU_op_o  = 3'b010;
        end
        S_R_WB: begin
          RegWrite_o = 1'b1;
          RegDst_o   = 1'b1;
        end
        S_I_EXEC: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
          ALU_op_o  = i_alu_op;
        end
        S_I_WB: begin
          RegWrite_o = 1'b1;
          ALU_op_o   = i_alu_op;
        end
        S_BRANCH: begin
          ALUSrcA_o     = 1'b1;
          ALU_op_o      = 3'b001;
          PCWriteCond_o = 1'b1;
          PCSource_o    = 2'b01;
        end
        S_JUMP: begin
          PCWrite_o  = 1'b1;
          PCSource_o = 2'b10;
        end
        S_ILLEGAL: begin
          illegal_o = ill_first;
        end
        default: ;
      endcase
    end
  end

  assign state_o   = state;
  assign retired_o = cnt;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed scoreboard bench for multi_cycle_ctrl.
// u0: skip-illegal with 4-bit counter; u1: trapping illegal.
module tb_multi_cycle_ctrl;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [3:0]  ret;
    logic        ill;
    logic [3:0]  st1;
    logic        ill1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] op;
  logic rdy;

  logic pw0, pwc0, iord0, mr0, mw0, irw0, m2r0, rd0, rw0, sa0;
  logic [1:0] sb0, ps0;
  logic [2:0] ao0;
  logic [3:0] st0;
  logic ill0;
  logic [3:0] ret0;

  logic pw1, pwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, sa1;
  logic [1:0] sb1, ps1;
  logic [2:0] ao1;
  logic [3:0] st1;
  logic ill1;
  logic [15:0] ret1;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic [3:0] ret_exp = 4'd0;
  bit trapped = 1'b0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(4), .ILL_TRAP(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .mem_ready_i(rdy),
    .PCWrite_o(pw0), .PCWriteCond_o(pwc0), .IorD_o(iord0),
    .MemRead_o(mr0), .MemWrite_o(mw0), .IRWrite_o(irw0),
    .MemtoReg_o(m2r0), .RegDst_o(rd0), .RegWrite_o(rw0),
    .ALUSrcA_o(sa0), .ALUSrcB_o(sb0), .ALU_op_o(ao0),
    .PCSource_o(ps0), .state_o(st0), .illegal_o(ill0),
    .retired_o(ret0)
  );

  multi_cycle_ctrl #(.CNT_W(16), .ILL_TRAP(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .mem_ready_i(rdy),
    .PCWrite_o(pw1), .PCWriteCond_o(pwc1), .IorD_o(iord1),
    .MemRead_o(mr1), .MemWrite_o(mw1), .IRWrite_o(irw1),
    .MemtoReg_o(m2r1), .RegDst_o(rd1), .RegWrite_o(rw1),
    .ALUSrcA_o(sa1), .ALUSrcB_o(sb1), .ALU_op_o(ao1),
    .PCSource_o(ps1), .state_o(st1), .illegal_o(ill1),
    .retired_o(ret1)
  );

  function automatic logic [16:0] exp_ctrl(int st, bit r, bit sl);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    pw = 0; pwc = 0; iord = 0; mr = 0; mw = 0;
    irw = 0; m2r = 0; rd = 0; rw = 0; sa = 0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    case (st)
      0: begin mr = 1; sb = 2'b01; irw = r; pw = r; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iord = 1; end
      6: begin sa = 1; ao = 3'b010; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; end
      9: begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; ao = sl ? 3'b011 : 3'b000; end
      11: begin rw = 1; ao = sl ? 3'b011 : 3'b000; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps};
  endfunction

  task automatic push(int st, bit r, bit sl, bit ill);
    exp_t e;
    if (rst) begin
      e.st = 4'd0; e.ctrl = '0; e.ret = 4'd0;
      e.ill = 1'b0; e.st1 = 4'd0; e.ill1 = 1'b0;
    end else begin
      e.st   = 4'(st);
      e.ctrl = exp_ctrl(st, r, sl);
      e.ret  = ret_exp;
      e.ill  = ill;
      e.st1  = trapped ? 4'd12 : 4'(st);
      e.ill1 = trapped ? 1'b0 : ill;
    end
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [16:0] obs;
    e = q.pop_front();
    obs = {pw0, pwc0, iord0, mr0, mw0, irw0, m2r0, rd0, rw0, sa0,
           sb0, ao0, ps0};
    total++;
    assert (st0 === e.st) else begin
      bad++;
      $error("FAIL state obs=%0d exp=%0d", st0, e.st);
    end
    total++;
    assert (obs === e.ctrl) else begin
      bad++;
      $error("FAIL ctrl st=%0d obs=%b exp=%b", e.st, obs, e.ctrl);
    end
    total++;
    assert (ret0 === e.ret) else begin
      bad++;
      $error("FAIL retired obs=%0d exp=%0d", ret0, e.ret);
    end
    total++;
    assert (ill0 === e.ill) else begin
      bad++;
      $error("FAIL illegal obs=%b exp=%b", ill0, e.ill);
    end
    total++;
    assert (st1 === e.st1) else begin
      bad++;
      $error("FAIL trap_state obs=%0d exp=%0d", st1, e.st1);
    end
    total++;
    assert (ill1 === e.ill1) else begin
      bad++;
      $error("FAIL trap_illegal obs=%b exp=%b", ill1, e.ill1);
    end
  endtask

  task automatic cyc(logic [5:0] o, bit r, int st,
                     bit sl = 1'b0, bit ill = 1'b0);
    op  = o;
    rdy = r;
    push(st, r, sl, ill);
    @(negedge clk);
    chk();
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    ret_exp = ret_exp + 4'd1;
  endtask

  initial begin
    rst = 1'b1;
    op  = 6'h00;
    rdy = 1'b0;
    push(0, 0, 0, 0);
    @(negedge clk);
    chk();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fetch stall, then R-type; opcode changes after decode are ignored
    cyc(6'h00, 0, 0);
    cyc(6'h00, 1, 0);
    cyc(6'h00, 1, 1);
    cyc(6'h3F, 1, 6);
    cyc(6'h3F, 1, 7); retire();

    // lw with 3-cycle read stall
    cyc(6'h23, 1, 0);
    cyc(6'h23, 1, 1);
    cyc(6'h00, 1, 2);
    cyc(6'h00, 0, 3);
    cyc(6'h00, 0, 3);
    cyc(6'h00, 0, 3);
    cyc(6'h00, 1, 3);
    cyc(6'h00, 1, 4); retire();

    // sw with one stall cycle
    cyc(6'h2B, 1, 0);
    cyc(6'h2B, 1, 1);
    cyc(6'h2B, 1, 2);
    cyc(6'h2B, 0, 5);
    cyc(6'h2B, 1, 5); retire();

    // addi, then slti with IR changed to addi after decode
    cyc(6'h08, 1, 0);
    cyc(6'h08, 1, 1);
    cyc(6'h08, 1, 10);
    cyc(6'h08, 1, 11); retire();
    cyc(6'h0A, 1, 0);
    cyc(6'h0A, 1, 1);
    cyc(6'h08, 1, 10, 1);
    cyc(6'h08, 1, 11, 1); retire();

    // beq then j
    cyc(6'h04, 1, 0);
    cyc(6'h04, 1, 1);
    cyc(6'h04, 1, 8); retire();
    cyc(6'h02, 1, 0);
    cyc(6'h02, 1, 1);
    cyc(6'h02, 1, 9); retire();

    // reset asserted while stalled in MEM_RD
    cyc(6'h23, 1, 0);
    cyc(6'h23, 1, 1);
    cyc(6'h23, 1, 2);
    cyc(6'h23, 0, 3);
    rst = 1'b1;
    ret_exp = 4'd0;
    #1;
    push(0, 0, 0, 0);
    chk();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(6'h00, 1, 0);
    cyc(6'h02, 1, 1);
    cyc(6'h02, 1, 9); retire();

    // illegal opcode: u0 skips, u1 traps
    cyc(6'h3F, 1, 0);
    cyc(6'h3F, 1, 1);
    cyc(6'h3F, 1, 12, 0, 1);
    trapped = 1'b1;
    cyc(6'h02, 1, 0);
    cyc(6'h02, 1, 1);
    cyc(6'h02, 1, 9); retire();
    cyc(6'h00, 1, 0);

    rst = 1'b1;
    ret_exp = 4'd0;
    trapped = 1'b0;
    #1;
    push(0, 0, 0, 0);
    chk();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 17 jumps wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      cyc(6'h02, 1, 0);
      cyc(6'h02, 1, 1);
      cyc(6'h02, 1, 9); retire();
    end
    cyc(6'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
